alu_arbiter: RTL

Shares the single picoMIPS `alu` instance between two requesters (e.g. the instruction datapath and an auxiliary address/MAC unit). Each requester submits an operation and two operands with a valid/ready handshake. The arbiter grants one request at a time (round-robin or fixed priority), drives the ALU from registered operands, captures the result, and returns it on a per-requester response channel with backpressure. The ALU itself stays purely combinational and sits outside this block.

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the two response channels and the
// shared ALU port of alu_arbiter. The arbiter connects through the slave
// modport. The requesters and the external combinational ALU connect through
// the master modport.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;

  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [7:0] rsp0_data;

  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  alu_a, alu_b, alu_op
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A request is accepted in IDLE, its operands drive the ALU from registers
// during EXEC, and the captured result is returned in RESP on the granted
// requester's response channel, which holds until it is taken.
module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic          clk,
  input  logic          n_reset,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic       gnt_q;
  logic       last_q;
  logic [1:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] rsp_q;
  logic       rsp0_valid_q;
  logic       rsp1_valid_q;
  logic       busy_q;

  logic       gnt_d;
  logic       ready0;
  logic       ready1;
  logic       accept;
  logic       rsp_done;
  logic [1:0] op_d;
  logic [7:0] a_d;
  logic [7:0] b_d;

  // Grant selection from the valid lines; on contention FAIR picks the
  // requester not served last, otherwise requester 0 wins.
  always_comb begin
    gnt_d = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_d = FAIR ? ~last_q : 1'b0;
    end else if (bus.req1_valid) begin
      gnt_d = 1'b1;
    end
  end

  // Handshake decode and selection of the grantee's operation.
  always_comb begin
    ready0   = (state_q == IDLE) && bus.req0_valid && !gnt_d;
    ready1   = (state_q == IDLE) && bus.req1_valid &&  gnt_d;
    accept   = ready0 || ready1;
    rsp_done = (rsp0_valid_q && bus.rsp0_ready) || (rsp1_valid_q && bus.rsp1_ready);
    op_d     = gnt_d ? bus.req1_op : bus.req0_op;
    a_d      = gnt_d ? bus.req1_a  : bus.req0_a;
    b_d      = gnt_d ? bus.req1_b  : bus.req0_b;
  end

  // Control FSM with registered operands, result, response valids and busy.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= gnt_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_q        <= bus.alu_result;
          rsp0_valid_q <= ~gnt_q;
          rsp1_valid_q <=  gnt_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_q       <= gnt_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp_q;
  assign bus.rsp1_data  = rsp_q;
  assign busy           = busy_q;

endmodule
